// File: rtl/pad_uart_tx.sv
// pad_uart_tx: 8N1 UART transmitter sending a frozen 5-byte game snapshot per accepted tick
module pad_uart_tx #(
  parameter int CLK_HZ = 65_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       timing_tick,
  input  logic       tx_en,
  input  logic [9:0] y_pad,
  input  logic [1:0] state,
  input  logic [3:0] player1_score,
  input  logic [3:0] player2_score,
  output logic       tx,
  output logic       busy,
  output logic       pkt_done
);
  localparam int DIV_R = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int DIV = DIV_R < 2 ? 2 : DIV_R;
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  typedef enum logic {IDLE, SEND} pkt_t;
  typedef enum logic [1:0] {START, DATA, STOP} ph_t;
  pkt_t pkt_q, pkt_d;
  ph_t ph_q, ph_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d, byte_q, byte_d;
  logic [39:0] snap_q, snap_d;
  logic tx_q, tx_d, done_q, done_d;
  logic [7:0] b1, b2, b3;
  logic go, adv;
  always_comb begin
    b1 = {state, 4'b0000, y_pad[9:8]};
    b2 = y_pad[7:0];
    b3 = {player1_score, player2_score};
    go = pkt_q == IDLE && timing_tick && tx_en;
    adv = pkt_q == SEND && baud_q == LAST;
    pkt_d = pkt_q;
    ph_d = ph_q;
    bit_d = bit_q;
    byte_d = byte_q;
    snap_d = snap_q;
    done_d = 1'b0;
    baud_d = (pkt_q == SEND && !adv) ? baud_q + 1'b1 : '0;
    if (go) begin
      pkt_d = SEND;
      ph_d = START;
      snap_d = {b1 ^ b2 ^ b3, b3, b2, b1, 8'hA5};
    end else if (adv) begin
      if (ph_q == START) begin
        ph_d = DATA;
      end else if (ph_q == DATA) begin
        ph_d = bit_q == 3'd7 ? STOP : DATA;
        bit_d = bit_q == 3'd7 ? 3'd0 : bit_q + 3'd1;
      end else begin
        ph_d = START;
        byte_d = byte_q == 3'd4 ? 3'd0 : byte_q + 3'd1;
        pkt_d = byte_q == 3'd4 ? IDLE : SEND;
        done_d = byte_q == 3'd4;
      end
    end
    tx_d = pkt_d == IDLE || ph_d == STOP || (ph_d == DATA && snap_d[{byte_d, bit_d}]);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_q <= IDLE;
      ph_q <= START;
      baud_q <= '0;
      bit_q <= '0;
      byte_q <= '0;
      snap_q <= '0;
      tx_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      pkt_q <= pkt_d;
      ph_q <= ph_d;
      baud_q <= baud_d;
      bit_q <= bit_d;
      byte_q <= byte_d;
      snap_q <= snap_d;
      tx_q <= tx_d;
      done_q <= done_d;
    end
  end
  assign tx = tx_q;
  assign busy = pkt_q == SEND;
  assign pkt_done = done_q;
endmodule

// File: tb/tb_pad_uart_tx.sv
// tb_pad_uart_tx: randomized scoreboard bench with a packet-level reference model and UART decoder
module tb_pad_uart_tx;
  localparam int DIV = 10;
  localparam int PKT = 50 * DIV;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic timing_tick = 1'b0;
  logic tx_en = 1'b1;
  logic [9:0] y_pad = '0;
  logic [1:0] state = '0;
  logic [3:0] player1_score = '0;
  logic [3:0] player2_score = '0;
  logic tx, busy, pkt_done;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int busy_end = 0;
  int done_at = -1;
  int m1, m2, m3;
  int mcnt = -1;
  logic [9:0] mbits;
  logic mglitch;
  logic [7:0] exp_q[$];
  pad_uart_tx #(.CLK_HZ(1_000_000), .BAUD(100_000)) dut (
    .clk(clk),
    .rst(rst),
    .timing_tick(timing_tick),
    .tx_en(tx_en),
    .y_pad(y_pad),
    .state(state),
    .player1_score(player1_score),
    .player2_score(player2_score),
    .tx(tx),
    .busy(busy),
    .pkt_done(pkt_done)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic pulse();
    @(negedge clk) timing_tick = 1'b1;
    @(negedge clk) timing_tick = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic load_rand();
    y_pad = 10'($urandom);
    state = 2'($urandom_range(0, 2));
    player1_score = 4'($urandom);
    player2_score = 4'($urandom);
  endtask
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_end = cyc;
      done_at = -1;
      exp_q.delete();
    end else begin
      cyc++;
      if (timing_tick && tx_en && !(cyc - 1 < busy_end)) begin
        m1 = state * 64 + y_pad / 256;
        m2 = y_pad % 256;
        m3 = player1_score * 16 + player2_score;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(m1));
        exp_q.push_back(8'(m2));
        exp_q.push_back(8'(m3));
        exp_q.push_back(8'(m1 ^ m2 ^ m3));
        busy_end = cyc + PKT;
        done_at = busy_end;
      end
    end
  end
  always @(negedge clk) begin
    if (!rst) begin
      check("busy", busy, cyc < busy_end);
      check("pkt_done", pkt_done, cyc == done_at);
      if (cyc >= busy_end) check("idle_tx", tx, 1);
    end
  end
  always @(negedge clk) begin
    if (rst) begin
      mcnt = -1;
    end else begin
      if (mcnt < 0 && tx === 1'b0) begin
        mcnt = 0;
        mglitch = 1'b0;
      end
      if (mcnt >= 0) begin
        if (mcnt % DIV == 0) mbits[mcnt / DIV] = tx;
        else if (tx !== mbits[mcnt / DIV]) mglitch = 1'b1;
        if (mcnt == 10 * DIV - 1) begin
          check("frame", {mglitch, mbits[0], mbits[9]}, 3'b001);
          if (exp_q.size() == 0) check("unexpected_byte", 0, 1);
          else check("byte", mbits[8:1], exp_q.pop_front());
          mcnt = -1;
        end else begin
          mcnt++;
        end
      end
    end
  end
  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_done", pkt_done, 0);
    idle(100);
    y_pad = 10'h2C7;
    state = 2'b01;
    player1_score = 4'd3;
    player2_score = 4'd4;
    pulse();
    check("start_lat", tx, 0);
    n = 1;
    while (!pkt_done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("done_lat", n, 501);
    idle(20);
    load_rand();
    pulse();
    idle(199);
    y_pad = 10'h000;
    pulse();
    idle(450);
    for (int i = 0; i < 3; i++) begin
      load_rand();
      pulse();
      check("b2b_start", tx, 0);
      idle(499);
    end
    idle(20);
    tx_en = 1'b0;
    pulse();
    check("gated_tx", tx, 1);
    check("gated_busy", busy, 0);
    idle(50);
    tx_en = 1'b1;
    load_rand();
    pulse();
    idle(150);
    tx_en = 1'b0;
    idle(400);
    pulse();
    idle(20);
    tx_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      load_rand();
      tx_en = $urandom_range(0, 3) != 0;
      pulse();
      idle($urandom_range(0, 600));
    end
    tx_en = 1'b1;
    idle(520);
    load_rand();
    pulse();
    idle(250);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_tx", tx, 1);
    check("arst_busy", busy, 0);
    @(negedge clk);
    idle(2);
    rst = 1'b0;
    load_rand();
    pulse();
    idle(520);
    check("leftover", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pad_uart_tx.md
# pad_uart_tx

UART transmitter carrying the local game snapshot (own paddle position, game state, both scores) to the opponent's board, where the player-2 paddle controller takes its UART-driven paddle position. The block launches one fixed 5-byte packet per accepted `timing_tick` while enabled. Each packet is a frozen snapshot, serialized 8N1, LSB first, on a single `tx` line. It sits beside the game-logic top level and is fed by the same FSM state, player-1 paddle and score registers.

## Interface
- `CLK_HZ`, default 65_000_000: system clock frequency in Hz.
- `BAUD`, default 115_200: line rate. Bit period is DIV = (CLK_HZ + BAUD/2) / BAUD cycles, rounded, minimum 2.

Ports:
- `clk` input, 1 bit: system clock; all logic is on the rising edge.
- `rst` input, 1 bit: reset, asynchronous and active-high.
- `timing_tick` input, 1 bit: one-cycle frame pulse that requests a packet.
- `tx_en` input, 1 bit: when low, new ticks are ignored; a packet already in flight always completes.
- `y_pad` input, 10 bits: local paddle Y position.
- `state` input, 2 bits: game FSM state (menu_start / play / game_over encoding).
- `player1_score` input, 4 bits: player 1 score.
- `player2_score` input, 4 bits: player 2 score.
- `tx` output, 1 bit: serial line, idle high.
- `busy` output, 1 bit: high from tick acceptance until the last stop bit ends.
- `pkt_done` output, 1 bit: one-cycle pulse at the end of each packet.

## Operation
- Packet layout, bytes B0..B4 in transmit order:
  - B0 = 8'hA5 (sync).
  - B1 = {state, 4'b0000, y_pad[9:8]}.
  - B2 = y_pad[7:0].
  - B3 = {player1_score, player2_score}.
  - B4 = B1 ^ B2 ^ B3 (8-bit XOR checksum).
- Acceptance: a tick is accepted in any cycle where `timing_tick & tx_en & ~busy`.
  - On acceptance, all inputs are registered into the snapshot and B4 is computed from that snapshot.
  - Input changes during transmission do not affect the packet.
- Ticks arriving while `busy` are dropped. They are not queued or counted.
- Packet FSM states: IDLE → SEND (byte index 0..4) → IDLE.
- Byte FSM per byte: START (tx=0), DATA (bits 0..7, LSB first), STOP (tx=1), each state lasting exactly one bit period.
- Bytes are back-to-back. The next byte's start bit directly follows the previous stop bit, with no idle gap.
- Baud counter counts 0..DIV-1 and reloads at every bit boundary. Width is $clog2(DIV).
- Bit index is 3 bits (0..7). Byte index is 3 bits (0..4). Both clear on packet end; neither wraps past its maximum.
- Reset values: `tx`=1, `busy`=0, `pkt_done`=0, FSM=IDLE, all counters 0, snapshot 0.
- Reset asserted mid-packet: `tx` returns high immediately (asynchronously) and the packet is abandoned. After release the block is IDLE and waits for the next tick. No partial packet is resumed.
- `tx_en` falling mid-packet: the packet finishes normally. Ticks are ignored from then on.

## Timing
- Tick accepted at rising edge N:
  - `busy`=1 and `tx`=0 (B0 start bit) from edge N+1.
  - `tx` is registered, never combinational.
- Bit k of the packet (k = 0..49, 10 bits per byte) drives `tx` during cycles N+1+k·DIV through N+(k+1)·DIV.
- The last stop bit ends at edge N+1+50·DIV. At that edge:
  - `busy` drops to 0;
  - `pkt_done` is high for that single cycle.
- A tick in that same cycle (busy=0) is accepted. The next start bit appears one cycle later, so the minimum packet-to-packet spacing is 50·DIV+1 cycles.
- At the defaults (DIV=564), a packet takes 28_200 cycles, well under one 60 Hz frame.

## Test plan
All scenarios use CLK_HZ=1_000_000 and BAUD=100_000, giving DIV=10.
- **Reset values:** hold `rst` for 3 cycles, then release → `tx`=1, `busy`=0, `pkt_done`=0; no activity for 100 cycles without a tick.
- **Basic packet:** `y_pad`=10'h2C7, `state`=2'b01, scores 3/4, one tick → UART monitor decodes A5, 42, C7, 34, B1 (B1 ^ B2 ^ B3 = 42 ^ C7 ^ 34). First start bit appears one cycle after the tick; every bit lasts exactly 10 cycles; `pkt_done` pulses at cycle 501 after the tick.
- **Snapshot and drop:** change `y_pad` to 10'h000 and pulse `timing_tick` at cycle 200 of a packet → the packet still carries the original y bytes; no second packet starts after `pkt_done`.
- **Back-to-back:** a tick coincident with the `pkt_done` cycle → a new start bit one cycle later; total spacing is 501 cycles.
- **Enable gating:** `tx_en`=0 with a tick → `tx` stays 1 and `busy` stays 0. Dropping `tx_en` mid-packet → the current packet completes with a valid checksum.
- **Async reset mid-packet:** assert `rst` between clock edges during B2 → `tx`=1 and `busy`=0 before the next edge. After release, a tick produces a complete, correct packet.
